mc_bx_sequencer: RTL and testbench
==================================

Name: mc_bx_sequencer

Overview:
- Per-BX scheduler for one MatchCalculator HLS instance (ap_start/ap_done/bx_V/bx_o_V).
- Issues one start per BX period, advances the 3-bit BX counter, and selects/clears the ping-pong nentries page for the FullMatch outputs.
- Checks that the returned BX matches the issued BX, and flags overruns when processing exceeds the period.
- Sits between the global run control and the MC instance inside the integration top.

Parameters:
- BX_W, 3, width of BX counter and BX ports.
- PERIOD, 108, clock cycles per BX slot; legal range 4..1023.
- CNT_W, 10, width of cycle counter; must satisfy 2^CNT_W > PERIOD.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- en_proc  in  1  run enable (level).
- bx_start  in  BX_W  first BX issued after leaving IDLE.
- mc_start  out  1  to MC ap_start.
- mc_bx  out  BX_W  to MC bx_V.
- mc_done  in  1  from MC ap_done (1-cycle pulse).
- mc_bx_o  in  BX_W  from MC bx_o_V; valid with mc_done.
- page_sel  out  1  FullMatch nentries page being written (= mc_bx[0]).
- page_clr  out  1  1-cycle pulse: zero nentries of page_sel.
- bx_out  out  BX_W  completed BX.
- bx_out_vld  out  1  1-cycle pulse per completed BX.
- busy  out  1  MC running.
- overrun  out  1  sticky: period elapsed before mc_done.
- bx_err  out  1  sticky: mc_bx_o != issued BX.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; cnt=0; internal bx=0; sticky flags cleared. Reset mid-run aborts immediately with no pulses.
- IDLE:
  - mc_start=0.
  - On en_proc=1: load bx=bx_start; next cycle enter RUN with mc_start=1, page_clr=1, cnt=0.
- RUN:
  - mc_start held 1 until the mc_done cycle inclusive; busy=1.
  - page_clr asserted only in the first RUN cycle.
  - mc_bx and page_sel stay stable for the whole RUN.
  - cnt increments every cycle, saturating at 2^CNT_W-1.
- On mc_done in RUN:
  - Next cycle: bx_out=mc_bx_o, bx_out_vld=1, busy=0.
  - bx_err set if mc_bx_o != bx.
  - Go to WAIT.
- WAIT:
  - cnt keeps counting.
  - When cnt==PERIOD-1: if en_proc=1, bx<=bx+1 (wraps 7->0), start a new RUN next cycle with cnt=0; else go to IDLE.
- Overrun:
  - Set if cnt==PERIOD-1 while in RUN.
  - That RUN continues. After mc_done, the next RUN starts in the cycle following bx_out_vld, with no extra WAIT and no BX skipped.
- en_proc deasserted during RUN: the current BX completes normally, then IDLE.
- mc_done outside RUN: ignored, but sets bx_err.
- mc_done in the first RUN cycle: accepted.
- Minimum BX-to-BX spacing is PERIOD cycles, start to start, when there is no overrun.

Optional Feature:
- Macro MC_SEQ_LATMON_EN.
- Defined:
  - Adds output max_lat[CNT_W] (reset 0).
  - On each mc_done, max_lat <= max(max_lat, cnt+1), i.e. RUN cycles of this BX.
  - Cleared only by reset.
- Undefined: no port, no logic; all other behaviour identical.

Decomposition:
- Shared package mc_seq_pkg:
  - typedef bx_t (BX_W bits).
  - state enum {IDLE, RUN, WAIT}.
  - constants BX_W_DEF=3, PERIOD_DEF=108.
- One natural sub-module, mc_seq_bxcnt: the BX counter with load/increment/wrap plus page_sel derivation.
- FSM, cycle counter and checks stay in the top.

Test Plan:
- Reset, en_proc=1, bx_start=5, MC model done after 50 cycles:
  - mc_start rises 1 cycle after en_proc with mc_bx=5, page_sel=1, page_clr pulse.
  - bx_out=5 with vld at cycle 51.
  - Next start at cycle 108 with mc_bx=6.
- Run 10 BXs from bx_start=6 -> mc_bx sequence 6,7,0,1,…; page_sel toggles each BX; no flags set.
- Done delayed to cycle 120 with PERIOD=108:
  - overrun=1 at cnt=107.
  - bx_out_vld the cycle after done; next mc_start the following cycle with bx+1.
- MC model returns mc_bx_o=3 when 2 was issued -> bx_err=1, sticky through later BXs until reset.
- en_proc dropped mid-RUN:
  - Current BX completes with bx_out_vld.
  - No further mc_start; state IDLE at cnt=107.
- reset pulsed mid-RUN:
  - Next cycle all outputs 0, with no bx_out_vld.
  - With MC_SEQ_LATMON_EN, max_lat=0 after reset; after runs of 50 and 80 cycles, max_lat=80.

Source files
------------

// File: rtl/mc_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mc_seq_pkg                                                   |
// | Description : Shared types and default constants for the MatchCalculator   |
// |               per-BX sequencer (BX type, FSM state encoding).              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mc_seq_pkg;

   // Default widths and period for one MatchCalculator slot
   localparam int BX_W_DEF   = 3;
   localparam int PERIOD_DEF = 108;
   localparam int CNT_W_DEF  = 10;

   // BX number as carried on the HLS bx_V / bx_o_V ports
   typedef logic [BX_W_DEF-1:0] bx_t;

   // Sequencer states: idle, MC running, waiting for the end of the BX slot
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      WAIT = 2'd2
   } state_t;

endpackage : mc_seq_pkg
`default_nettype wire

// File: rtl/mc_seq_bxcnt.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mc_seq_bxcnt                                                 |
// | Description : BX counter for the MatchCalculator sequencer. Loads the      |
// |               first BX on start-up, increments (with natural wrap) at      |
// |               each new BX slot and derives the nentries ping-pong page.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mc_seq_bxcnt
   import mc_seq_pkg::*;
#(
   parameter int BX_W = BX_W_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic [BX_W-1:0] load_val,
   input  logic            inc,
   output logic [BX_W-1:0] bx,
   output logic            page_sel
);

   logic [BX_W-1:0] r_bx;

   // BX register: load has priority; increment wraps modulo 2^BX_W
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bx <= '0;
      end else if (load) begin
         r_bx <= load_val;
      end else if (inc) begin
         r_bx <= r_bx + BX_W'(1);
      end
   end

   assign bx = r_bx;

   // Even/odd BX select the two halves of the FullMatch nentries memory
   assign page_sel = r_bx[0];

endmodule : mc_seq_bxcnt
`default_nettype wire

// File: rtl/mc_bx_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mc_bx_sequencer                                              |
// | Description : Per-BX scheduler for one MatchCalculator HLS instance.       |
// |               Issues one ap_start per BX slot of PERIOD cycles, advances   |
// |               the BX number, selects/clears the nentries page, checks the  |
// |               returned BX and flags overruns.                              |
// |               Optional: define MC_SEQ_LATMON_EN to add the max_lat output  |
// |               (largest RUN length seen since reset).                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mc_bx_sequencer
   import mc_seq_pkg::*;
#(
   parameter int BX_W   = BX_W_DEF,
   parameter int PERIOD = PERIOD_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en_proc,
   input  logic [BX_W-1:0]  bx_start,
   output logic             mc_start,
   output logic [BX_W-1:0]  mc_bx,
   input  logic             mc_done,
   input  logic [BX_W-1:0]  mc_bx_o,
   output logic             page_sel,
   output logic             page_clr,
   output logic [BX_W-1:0]  bx_out,
   output logic             bx_out_vld,
   output logic             busy,
   output logic             overrun,
   output logic             bx_err
`ifdef MC_SEQ_LATMON_EN
   ,
   output logic [CNT_W-1:0] max_lat
`endif
);

   localparam logic [CNT_W-1:0] c_PERIOD_M1 = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] c_CNT_MAX   = {CNT_W{1'b1}};

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic             w_cnt_clr;
   logic             w_bx_load;
   logic             w_bx_inc;
   logic             w_in_run;
   logic             w_done_run;
   logic             w_at_limit;
   logic             w_period_end;
   logic [BX_W-1:0]  w_bx;
   logic             r_bx_out_vld;
   logic [BX_W-1:0]  r_bx_out;
   logic             r_overrun;
   logic             r_bx_err;

   assign w_in_run   = (r_state == RUN);
   assign w_done_run = w_in_run && mc_done;
   assign w_at_limit = (r_cnt == c_PERIOD_M1);
   // ">=" lets a slot that overran start its successor right after bx_out_vld
   assign w_period_end = (r_cnt >= c_PERIOD_M1);

   // BX number and nentries page for the slot currently being processed
   mc_seq_bxcnt #(
      .BX_W (BX_W)
   ) u_bxcnt (
      .clk      (clk),
      .reset    (reset),
      .load     (w_bx_load),
      .load_val (bx_start),
      .inc      (w_bx_inc),
      .bx       (w_bx),
      .page_sel (page_sel)
   );

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic with BX counter and cycle counter controls
   always_comb begin
      w_state_nxt = r_state;
      w_bx_load   = 1'b0;
      w_bx_inc    = 1'b0;
      w_cnt_clr   = 1'b0;
      case (r_state)
         IDLE: begin
            if (en_proc) begin
               w_state_nxt = RUN;
               w_bx_load   = 1'b1;
               w_cnt_clr   = 1'b1;
            end
         end
         RUN: begin
            // en_proc is not looked at here: a started BX always completes
            if (mc_done) begin
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (w_period_end) begin
               if (en_proc) begin
                  w_state_nxt = RUN;
                  w_bx_inc    = 1'b1;
                  w_cnt_clr   = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Cycle counter: restarts at each new slot, saturates, parked at 0 in IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_cnt_clr || (r_state == IDLE)) begin
         r_cnt <= '0;
      end else if (r_cnt != c_CNT_MAX) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   // Completion report: one-cycle valid carrying the BX returned by the MC
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bx_out_vld <= 1'b0;
         r_bx_out     <= '0;
      end else begin
         r_bx_out_vld <= w_done_run;
         if (w_done_run) begin
            r_bx_out <= mc_bx_o;
         end
      end
   end

   // Sticky error flags: slot overrun, and returned BX mismatch or stray done
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overrun <= 1'b0;
         r_bx_err  <= 1'b0;
      end else begin
         if (w_in_run && w_at_limit) begin
            r_overrun <= 1'b1;
         end
         if (mc_done && (!w_in_run || (mc_bx_o != w_bx))) begin
            r_bx_err <= 1'b1;
         end
      end
   end

   assign mc_start   = w_in_run;
   assign busy       = w_in_run;
   assign mc_bx      = w_bx;
   // Counter is cleared on RUN entry and never wraps, so 0 marks the first cycle
   assign page_clr   = w_in_run && (r_cnt == '0);
   assign bx_out     = r_bx_out;
   assign bx_out_vld = r_bx_out_vld;
   // Raised already in the cycle the limit is hit, then held by the register
   assign overrun    = r_overrun | (w_in_run && w_at_limit);
   assign bx_err     = r_bx_err;

`ifdef MC_SEQ_LATMON_EN
   logic [CNT_W-1:0] r_max_lat;
   logic [CNT_W-1:0] w_lat;

   // RUN length of the current BX, saturating with the counter
   assign w_lat = (r_cnt == c_CNT_MAX) ? c_CNT_MAX : (r_cnt + CNT_W'(1));

   // Peak-hold of the RUN length, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_max_lat <= '0;
      end else if (w_done_run && (w_lat > r_max_lat)) begin
         r_max_lat <= w_lat;
      end
   end

   assign max_lat = r_max_lat;
`endif

endmodule : mc_bx_sequencer
`default_nettype wire

// File: tb/tb_mc_bx_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mc_bx_sequencer                                           |
// | Description : Self-checking bench for mc_bx_sequencer. Each table record   |
// |               describes one BX slot (MC latency, returned BX, en_proc) and |
// |               the expected outputs; reset and start-up are hand-written.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mc_bx_sequencer;

   localparam int BXW = 3;
   localparam int PER = 108;
   localparam int CW  = 10;

   logic           clk = 1'b0;
   logic           reset;
   logic           en_proc;
   logic [BXW-1:0] bx_start;
   logic           mc_start;
   logic [BXW-1:0] mc_bx;
   logic           mc_done;
   logic [BXW-1:0] mc_bx_o;
   logic           page_sel;
   logic           page_clr;
   logic [BXW-1:0] bx_out;
   logic           bx_out_vld;
   logic           busy;
   logic           overrun;
   logic           bx_err;
`ifdef MC_SEQ_LATMON_EN
   logic [CW-1:0]  max_lat;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   mc_bx_sequencer #(
      .BX_W   (BXW),
      .PERIOD (PER),
      .CNT_W  (CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .en_proc    (en_proc),
      .bx_start   (bx_start),
      .mc_start   (mc_start),
      .mc_bx      (mc_bx),
      .mc_done    (mc_done),
      .mc_bx_o    (mc_bx_o),
      .page_sel   (page_sel),
      .page_clr   (page_clr),
      .bx_out     (bx_out),
      .bx_out_vld (bx_out_vld),
      .busy       (busy),
      .overrun    (overrun),
      .bx_err     (bx_err)
`ifdef MC_SEQ_LATMON_EN
      ,
      .max_lat    (max_lat)
`endif
   );

   always #5 clk = ~clk;

   // One record per BX slot: MC latency (done at cnt=delay), optional wrong
   // returned BX, en_proc during the slot, and expected results.
   typedef struct {
      int             delay;
      bit             force_bxo;
      logic [BXW-1:0] bxo;
      bit             en_run;
      logic [BXW-1:0] exp_bx;
      bit             exp_page;
      bit             ovr_pre;
      bit             exp_ovr;
      bit             exp_err;
      int             exp_gap;   // start-to-start cycles, 0 = expect IDLE
   } vec_t;

   vec_t vecs[17];

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_mc_start"},   32'(mc_start),   0);
      chk({tag, "_mc_bx"},      32'(mc_bx),      0);
      chk({tag, "_page_sel"},   32'(page_sel),   0);
      chk({tag, "_page_clr"},   32'(page_clr),   0);
      chk({tag, "_bx_out"},     32'(bx_out),     0);
      chk({tag, "_bx_out_vld"}, 32'(bx_out_vld), 0);
      chk({tag, "_busy"},       32'(busy),       0);
      chk({tag, "_overrun"},    32'(overrun),    0);
      chk({tag, "_bx_err"},     32'(bx_err),     0);
   endtask

   // Called right after en_proc is raised in IDLE; the first RUN cycle must follow
   task automatic wait_start(input string tag);
      int waited;
      waited = 0;
      tick();
      waited = 1;
      while (page_clr !== 1'b1 && waited < 8) begin
         tick();
         waited++;
      end
      chk({tag, "_start_latency"}, 32'(waited), 1);
   endtask

   // Entered at the negedge of the first RUN cycle of the slot
   task automatic apply_vec(input vec_t v, input string tag);
      int bad;
      int rel;
      bit seen;
      logic [BXW-1:0] exp_out;
      bad     = 0;
      exp_out = v.force_bxo ? v.bxo : v.exp_bx;
      en_proc = v.en_run;
      for (int k = 0; k <= v.delay; k++) begin
         if (mc_start !== 1'b1 || busy !== 1'b1 || page_clr !== (k == 0) ||
             mc_bx !== v.exp_bx || page_sel !== v.exp_page || bx_out_vld !== 1'b0)
            bad++;
         if (k == PER - 2) chk({tag, "_overrun_cnt106"}, 32'(overrun), 32'(v.ovr_pre));
         if (k == PER - 1) chk({tag, "_overrun_cnt107"}, 32'(overrun), 1);
         if (k == v.delay) begin
            mc_done = 1'b1;
            mc_bx_o = exp_out;
         end
         tick();
      end
      mc_done = 1'b0;
      mc_bx_o = '0;
      chk({tag, "_run_cycles_bad"}, 32'(bad), 0);
      chk({tag, "_bx_out_vld"}, 32'(bx_out_vld), 1);
      chk({tag, "_bx_out"}, 32'(bx_out), 32'(exp_out));
      chk({tag, "_busy_after_done"}, 32'(busy), 0);
      tick();
      chk({tag, "_vld_one_cycle"}, 32'(bx_out_vld), 0);
      rel = v.delay + 2;
      if (v.exp_gap > 0) begin
         while (page_clr !== 1'b1 && rel < v.exp_gap + 20) begin
            tick();
            rel++;
         end
         chk({tag, "_start_gap"}, 32'(rel), 32'(v.exp_gap));
      end else begin
         seen = 1'b0;
         for (int j = 0; j < 200; j++) begin
            if (mc_start !== 1'b0 || busy !== 1'b0) seen = 1'b1;
            tick();
         end
         chk({tag, "_no_restart"}, 32'(seen), 0);
      end
      chk({tag, "_overrun"}, 32'(overrun), 32'(v.exp_ovr));
      chk({tag, "_bx_err"}, 32'(bx_err), 32'(v.exp_err));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Segment 1 from bx_start=5: overrun at slot 7, wrong BX returned at slot 2
      //          delay frc bxo en  bx  pg pre ovr err gap
      vecs[0]  = '{50,  0,  0,  1,  5,  1, 0,  0,  0,  108};
      vecs[1]  = '{20,  0,  0,  1,  6,  0, 0,  0,  0,  108};
      vecs[2]  = '{120, 0,  0,  1,  7,  1, 0,  1,  0,  122};
      vecs[3]  = '{0,   0,  0,  1,  0,  0, 1,  1,  0,  108};
      vecs[4]  = '{60,  0,  0,  1,  1,  1, 1,  1,  0,  108};
      vecs[5]  = '{33,  1,  3,  1,  2,  0, 1,  1,  1,  108};
      vecs[6]  = '{45,  0,  0,  0,  3,  1, 1,  1,  1,  0};
      // Segment 2 from bx_start=6: ten clean slots, wrap 7->0
      vecs[7]  = '{10,  0,  0,  1,  6,  0, 0,  0,  0,  108};
      vecs[8]  = '{99,  0,  0,  1,  7,  1, 0,  0,  0,  108};
      vecs[9]  = '{5,   0,  0,  1,  0,  0, 0,  0,  0,  108};
      vecs[10] = '{70,  0,  0,  1,  1,  1, 0,  0,  0,  108};
      vecs[11] = '{1,   0,  0,  1,  2,  0, 0,  0,  0,  108};
      vecs[12] = '{106, 0,  0,  1,  3,  1, 0,  0,  0,  108};
      vecs[13] = '{50,  0,  0,  1,  4,  0, 0,  0,  0,  108};
      vecs[14] = '{0,   0,  0,  1,  5,  1, 0,  0,  0,  108};
      vecs[15] = '{80,  0,  0,  1,  6,  0, 0,  0,  0,  108};
      vecs[16] = '{25,  0,  0,  0,  7,  1, 0,  0,  0,  0};

      reset    = 1'b1;
      en_proc  = 1'b0;
      bx_start = '0;
      mc_done  = 1'b0;
      mc_bx_o  = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk_all_zero("reset");

      // Start-up: mc_start one cycle after en_proc, BX 5 on the odd page
      bx_start = 3'd5;
      en_proc  = 1'b1;
      chk("pre_start_mc_start", 32'(mc_start), 0);
      wait_start("seg1");
      chk("seg1_first_mc_bx", 32'(mc_bx), 5);
      chk("seg1_first_page_sel", 32'(page_sel), 1);
      for (int i = 0; i <= 6; i++) apply_vec(vecs[i], $sformatf("seg1_v%0d", i));

      // Reset in the middle of a RUN, coinciding with mc_done: no pulses
      bx_start = 3'd2;
      en_proc  = 1'b1;
      wait_start("midrst");
      chk("midrst_mc_bx", 32'(mc_bx), 2);
      repeat (20) tick();
      reset   = 1'b1;
      mc_done = 1'b1;
      mc_bx_o = 3'd2;
      en_proc = 1'b0;
      tick();
      reset   = 1'b0;
      mc_done = 1'b0;
      chk_all_zero("midrst");
      tick();
      chk("midrst_vld_later", 32'(bx_out_vld), 0);
      chk("midrst_idle", 32'(mc_start), 0);

      // Ten BXs from bx_start=6; flags cleared by the reset above
      bx_start = 3'd6;
      en_proc  = 1'b1;
      wait_start("seg2");
      for (int i = 7; i <= 16; i++) apply_vec(vecs[i], $sformatf("seg2_v%0d", i));

`ifdef MC_SEQ_LATMON_EN
      begin
         vec_t lv[2];
         lv[0] = '{49, 0, 0, 1, 0, 0, 0, 0, 0, 108};
         lv[1] = '{79, 0, 0, 0, 1, 1, 0, 0, 0, 0};
         reset = 1'b1;
         tick();
         reset = 1'b0;
         tick();
         chk("latmon_reset", 32'(max_lat), 0);
         bx_start = 3'd0;
         en_proc  = 1'b1;
         wait_start("latmon");
         apply_vec(lv[0], "latmon_v0");
         chk("latmon_after_50", 32'(max_lat), 50);
         apply_vec(lv[1], "latmon_v1");
         chk("latmon_after_80", 32'(max_lat), 80);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_mc_bx_sequencer
`default_nettype wire
